// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller for the EX stage: single-pass multiply,
// 32-step restoring divide, pipeline stall generation and a one-cycle HI/LO write.
module mdu_ctrl #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CW        = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
  localparam logic [CW-1:0]   LAST_STEP = CW'(DIV_STEPS - 1);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          mul_signed_q, mul_signed_d;
  logic          sign_quo_q, sign_quo_d;
  logic          sign_rem_q, sign_rem_d;
  // {rem, quo} while dividing; low half holds the multiplicand during MUL
  logic [63:0]   rq_q, rq_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic [31:0]   res_lo_q, res_lo_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q;

  logic [63:0]   mul_a_s;
  logic [63:0]   mul_b_s;
  logic [63:0]   prod_s;
  logic [32:0]   trial_s;
  logic [33:0]   diff_s;
  logic          no_borrow_s;
  logic [31:0]   rem_step_s;
  logic [31:0]   quo_step_s;
  logic          commit_s;

  // Datapath: sign-extended 64-bit product and one restoring divide step.
  always_comb begin
    mul_a_s     = {{32{mul_signed_q & rq_q[31]}}, rq_q[31:0]};
    mul_b_s     = {{32{mul_signed_q & dvs_q[31]}}, dvs_q};
    prod_s      = mul_a_s * mul_b_s;
    trial_s     = rq_q[63:31];
    diff_s      = {1'b0, trial_s} - {2'b00, dvs_q};
    no_borrow_s = ~diff_s[33];
    rem_step_s  = no_borrow_s ? diff_s[31:0] : trial_s[31:0];
    quo_step_s  = {rq_q[30:0], no_borrow_s};
  end

  // Next-state and operand/result sequencing; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mul_signed_d = mul_signed_q;
    sign_quo_d   = sign_quo_q;
    sign_rem_d   = sign_rem_q;
    rq_d         = rq_q;
    dvs_d        = dvs_q;
    res_hi_d     = res_hi_q;
    res_lo_d     = res_lo_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mul_signed_d = ~op[0];
            if (!op[1]) begin
              state_d = S_MUL;
              rq_d    = {32'd0, a};
              dvs_d   = b;
            end else if (b != 32'd0) begin
              state_d    = S_DIV;
              count_d    = '0;
              rq_d       = {32'd0, op[0] ? a : abs32(a)};
              dvs_d      = op[0] ? b : abs32(b);
              sign_quo_d = ~op[0] & (a[31] ^ b[31]);
              sign_rem_d = ~op[0] & a[31];
            end else begin
              state_d  = S_DONE;
              res_hi_d = a;
              res_lo_d = 32'hFFFF_FFFF;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          res_hi_d = prod_s[63:32];
          res_lo_d = prod_s[31:0];
          state_d  = S_DONE;
        end
        S_DIV: begin
          rq_d    = {rem_step_s, quo_step_s};
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          if (count_q == LAST_STEP) begin
            state_d  = S_DONE;
            res_lo_d = sign_quo_q ? neg32(quo_step_s) : quo_step_s;
            res_hi_d = sign_rem_q ? neg32(rem_step_s) : rem_step_s;
          end else begin
            state_d = S_DIV;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      mul_signed_q <= 1'b0;
      sign_quo_q   <= 1'b0;
      sign_rem_q   <= 1'b0;
      rq_q         <= 64'd0;
      dvs_q        <= 32'd0;
      res_hi_q     <= 32'd0;
      res_lo_q     <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      mul_signed_q <= mul_signed_d;
      sign_quo_q   <= sign_quo_d;
      sign_rem_q   <= sign_rem_d;
      rq_q         <= rq_d;
      dvs_q        <= dvs_d;
      res_hi_q     <= res_hi_d;
      res_lo_q     <= res_lo_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  // Outputs: the pending result is visible during an unflushed DONE cycle only,
  // so a flush in DONE leaves HI/LO at their previously written values.
  always_comb begin
    commit_s = ~rst & ~flush & (state_q == S_DONE);
    stall    = ~rst & ~flush &
               (((state_q == S_IDLE) & start) | (state_q == S_MUL) | (state_q == S_DIV));
    busy     = busy_q;
    hilo_we  = commit_s;
    hi_out   = commit_s ? res_hi_q : hi_q;
    lo_out   = commit_s ? res_lo_q : lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases, flush/reset corners and
// randomized operations compared against an arithmetic reference model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_hi  = 32'd0;
  logic [31:0] last_lo  = 32'd0;
  logic        prev_we  = 1'b0;

  mdu_ctrl #(.DIV_STEPS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sx;
    int                 sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: begin
        sp = longint'(sx) * longint'(sy);
        eh = sp[63:32];
        el = sp[31:0];
      end
      2'd1: begin
        up = {32'd0, x} * {32'd0, y};
        eh = up[63:32];
        el = up[31:0];
      end
      2'd2: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          eh = 32'd0; el = 32'h8000_0000;
        end else begin
          el = sx / sy;
          eh = sx % sy;
        end
      end
      default: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF;
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  // One complete operation: latency, stall count and result; optional idle cycle after DONE.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit gap);
    logic [31:0] eh;
    logic [31:0] el;
    int          exp_c;
    int          c;
    int          stalls;
    bit          seen;
    ref_model(o, x, y, eh, el);
    exp_c = (!o[1]) ? 2 : ((y == 32'd0) ? 1 : 33);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
    #1;
    c = 0; stalls = 0; seen = 1'b0;
    while (!seen && c < 40) begin
      if (stall === 1'b1) stalls++;
      if (hilo_we === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge clk); #1; c++;
      end
    end
    chk("done_seen", seen, 1);
    chk("done_cycle", c, exp_c);
    chk("stall_cycles", stalls, exp_c);
    chk("busy_in_done", busy, 1);
    chk("hi_result", hi_out, eh);
    chk("lo_result", lo_out, el);
    last_hi = eh;
    last_lo = el;
    if (gap) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_we", hilo_we, 0);
      chk("idle_hi_hold", hi_out, last_hi);
      chk("idle_lo_hold", lo_out, last_lo);
    end
  endtask

  // Protocol monitor: no back-to-back write strobes and never a stall with the strobe.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        n_checks++;
        assert (!(hilo_we && prev_we)) else begin
          n_fail++;
          $error("FAIL we_twice: observed %b%b expected not 11", prev_we, hilo_we);
        end
        n_checks++;
        assert (!(hilo_we && stall)) else begin
          n_fail++;
          $error("FAIL stall_in_done: observed stall %b we %b expected stall 0", stall, hilo_we);
        end
      end
      prev_we = hilo_we;
    end
  end

  initial begin
    int we_cnt;
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int          sel;

    rst = 1'b1; start = 1'b1; op = 2'd2; a = 32'd50; b = 32'd3; flush = 1'b0;
    @(negedge clk); #1;
    chk("stall_in_reset", stall, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);

    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(2'd3, 32'd100, 32'd7, 1'b0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(2'd3, 32'h0000_1234, 32'd0, 1'b1);
    do_op(2'd2, 32'hFFFF_0000, 32'd0, 1'b1);

    // Flush in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3; flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("div_pre_flush_stall", stall, 1);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_we", hilo_we, 0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_hi_hold", hi_out, last_hi);
    chk("flush_lo_hold", lo_out, last_lo);
    we_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hilo_we === 1'b1) we_cnt++;
    end
    chk("flush_no_write", we_cnt, 0);
    chk("flush_hi_later", hi_out, last_hi);
    do_op(2'd0, 32'd6, 32'd7, 1'b1);

    // Flush landing on the DONE cycle suppresses the write.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9; flush = 1'b0;
    #1; chk("mul_c0_stall", stall, 1);
    @(negedge clk); #1; chk("mul_c1_stall", stall, 1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("done_flush_we", hilo_we, 0);
    chk("done_flush_stall", stall, 0);
    chk("done_flush_hi", hi_out, last_hi);
    chk("done_flush_lo", lo_out, last_lo);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("done_flush_busy", busy, 0);
    chk("done_flush_we_next", hilo_we, 0);

    // Flush together with start in IDLE: nothing is accepted.
    @(negedge clk);
    start = 1'b1; op = 2'd0; flush = 1'b1;
    #1; chk("idle_flush_stall", stall, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1; chk("idle_flush_busy", busy, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd77; b = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1; chk("mid_rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", hilo_we, 0);
    chk("mid_rst_hi", hi_out, 0);
    chk("mid_rst_lo", lo_out, 0);
    last_hi = 32'd0; last_lo = 32'd0;

    for (int i = 0; i < 1200; i++) begin
      ro  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      ry  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
            (sel == 2) ? 32'hFFFF_FFFF : 32'($urandom);
      sel = $urandom_range(0, 7);
      rx  = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
      do_op(ro, rx, ry, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
